matmul_loader: RTL and testbench

Operand loader for the `matmul` engine. It receives one frame of int8 operands as a byte stream. Bytes are packed four per 32-bit word and written into matmul's A (P×P matrix) and B (P-vector) operand memories. After the last word it pulses `start` and holds off the next frame until matmul signals `mm_done`. It is the writer side of the operand memories that `matmul` reads.

---
 rtl/matmul_pkg.sv | 22 ++
 rtl/matmul_loader_byte_packer.sv | 41 ++++
 rtl/matmul_loader.sv | 113 +++++++++++
 tb/tb_matmul_loader.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// rtl/matmul_pkg.sv - shared matmul sizes, loader state enum and memory selects
package matmul_pkg;

  localparam int P           = 8;
  localparam int A_WORDS     = P * P / 4;
  localparam int B_WORDS     = P / 4;
  localparam int FRAME_BYTES = P * P + P;
  localparam int CNT_W       = $clog2(FRAME_BYTES);

  localparam logic MEM_A = 1'b0;
  localparam logic MEM_B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_A,
    LOAD_B,
    START,
    WAIT,
    FLUSH
  } state_t;

endpackage

// File: rtl/matmul_loader_byte_packer.sv
// rtl/matmul_loader_byte_packer.sv - little-endian byte to 32-bit word packer
module byte_packer (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        clr,
  input  logic [7:0]  data,
  output logic [31:0] word,
  output logic        word_valid
);

  logic [1:0]  lane;
  logic [23:0] low;

  // Collect three low bytes, then publish the full word with a one-cycle strobe.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lane       <= 2'd0;
      low        <= 24'd0;
      word       <= 32'd0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= 1'b0;
      if (clr) begin
        lane <= 2'd0;
      end else if (en) begin
        lane <= lane + 2'd1;
        case (lane)
          2'd0:    low[7:0]   <= data;
          2'd1:    low[15:8]  <= data;
          2'd2:    low[23:16] <= data;
          default: begin
            word       <= {data, low};
            word_valid <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/matmul_loader.sv
// rtl/matmul_loader.sv - operand frame loader writing matmul A/B memories
module matmul_loader
  import matmul_pkg::*;
#(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [7:0]        s_data,
  input  logic              s_last,
  output logic              mem_we,
  output logic              mem_sel,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              start,
  input  logic              mm_done,
  output logic              busy,
  output logic              err
);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   byte_cnt;
  logic [CNT_W-1:0]   idx;
  logic [ADDR_W-1:0]  wr_addr;
  logic               acc, loading, is_final, early_last, take, word_done, missing_last;

  // The byte accepted in IDLE is always byte 0 of a new frame.
  assign acc          = s_valid && s_ready;
  assign loading      = state_q inside {IDLE, LOAD_A, LOAD_B};
  assign idx          = (state_q == IDLE) ? '0 : byte_cnt;
  assign is_final     = (idx == CNT_W'(FRAME_BYTES - 1));
  assign early_last   = acc && loading && s_last && !is_final;
  assign take         = acc && loading && !early_last;
  assign word_done    = take && (idx[1:0] == 2'b11);
  assign missing_last = take && is_final && !s_last;
  assign busy         = (state_q != IDLE);

  byte_packer u_packer (
    .clk        (clk),
    .resetn     (resetn),
    .en         (take),
    .clr        (early_last),
    .data       (s_data),
    .word       (mem_wdata),
    .word_valid (mem_we)
  );

  // Next-state and ready; START holds two cycles so the registered start pulse lands inside it.
  always_comb begin
    state_d = state_q;
    s_ready = 1'b1;
    case (state_q)
      IDLE:   if (take) state_d = LOAD_A;
      LOAD_A: begin
        if (early_last) state_d = IDLE;
        else if (take && idx == CNT_W'(P * P - 1)) state_d = LOAD_B;
      end
      LOAD_B: begin
        if (early_last) state_d = IDLE;
        else if (take && is_final) state_d = s_last ? START : FLUSH;
      end
      START: begin
        s_ready = 1'b0;
        if (start) state_d = WAIT;
      end
      WAIT: begin
        s_ready = 1'b0;
        if (mm_done) state_d = IDLE;
      end
      FLUSH:  if (acc && s_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, byte/word counters, write address/select, start pulse and sticky error.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      byte_cnt <= '0;
      wr_addr  <= '0;
      mem_sel  <= MEM_A;
      mem_addr <= '0;
      start    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state_q <= state_d;
      start   <= (state_q == START) && !start;

      if (early_last) begin
        byte_cnt <= '0;
        wr_addr  <= '0;
      end else if (take) begin
        byte_cnt <= is_final ? '0 : idx + CNT_W'(1);
      end

      if (word_done) begin
        mem_sel  <= (state_q == LOAD_B) ? MEM_B : MEM_A;
        mem_addr <= wr_addr;
        if ((state_q == LOAD_A && wr_addr == ADDR_W'(A_WORDS - 1)) ||
            (state_q == LOAD_B && wr_addr == ADDR_W'(B_WORDS - 1)))
          wr_addr <= '0;
        else
          wr_addr <= wr_addr + ADDR_W'(1);
      end

      if (early_last || missing_last) err <= 1'b1;
      else if (acc && state_q == IDLE) err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_matmul_loader.sv
// tb/tb_matmul_loader.sv - self-checking bench for matmul_loader
module tb_matmul_loader;
  import matmul_pkg::*;

  localparam int ADDR_W = 6;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic              s_valid = 1'b0;
  logic [7:0]        s_data = 8'd0;
  logic              s_last = 1'b0;
  logic              mm_done = 1'b0;
  logic              s_ready, mem_we, mem_sel, start, busy, err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  matmul_loader #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .mem_we(mem_we), .mem_sel(mem_sel),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .start(start),
    .mm_done(mm_done), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        sel;
    int          addr;
    logic [31:0] data;
    int          cyc;
  } wr_t;

  wr_t         exp_q[$];
  int          start_q[$];
  int          n_tests = 0, n_fail = 0;
  int          wr_cnt = 0, wr_a_cnt = 0, start_cnt = 0, last_acc = 0;
  bit          hold = 1'b0;
  logic [7:0]  fbuf [0:127];
  logic [31:0] log_a [A_WORDS];
  logic [31:0] log_b [B_WORDS];

  function automatic logic [7:0] bval(input int pat, input int i);
    return (pat == 0) ? 8'(i) : 8'(i + 128);
  endfunction

  function automatic logic [43:0] outs();
    return {s_ready, busy, mem_we, mem_sel, mem_addr, mem_wdata, start, err};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic monitor();
    wr_t e;
    chk("s_ready", 64'(s_ready), 64'(!hold));
    if (mem_we === 1'b1) begin
      wr_cnt++;
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_write: sel %0d addr %0d data 0x%08h, expected no write", mem_sel, mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        chk("write_sel_addr_data", 64'({mem_sel, mem_addr, mem_wdata}), 64'({e.sel, ADDR_W'(e.addr), e.data}));
        chk("write_cycle", 64'(cyc), 64'(e.cyc));
      end
      if (mem_sel == 1'b0) begin
        wr_a_cnt++;
        if (int'(mem_addr) < A_WORDS) log_a[int'(mem_addr)] = mem_wdata;
      end else if (int'(mem_addr) < B_WORDS) begin
        log_b[int'(mem_addr)] = mem_wdata;
      end
    end
    if (start === 1'b1) begin
      start_cnt++;
      if (start_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_start: start at cycle %0d, expected none", cyc);
      end else begin
        chk("start_cycle", 64'(cyc), 64'(start_q.pop_front()));
      end
    end
  endtask

  task automatic step(output logic rdy);
    @(negedge clk);
    monitor();
    rdy = s_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    logic r;
    for (int k = 0; k < n; k++) step(r);
  endtask

  task automatic send_byte(input int i, input logic [7:0] d, input logic last);
    logic rdy;
    bit   done;
    wr_t  e;
    done    = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    s_last  = last;
    for (int k = 0; k < 100 && !done; k++) begin
      step(rdy);
      if (rdy) done = 1'b1;
    end
    if (!done) begin
      n_tests++;
      n_fail++;
      $display("FAIL accept_timeout: byte %0d not accepted, expected acceptance", i);
      return;
    end
    last_acc = cyc;
    if (i < 128) fbuf[i] = d;
    if (i < FRAME_BYTES && i % 4 == 3 && !(last && i != FRAME_BYTES - 1)) begin
      e.data = {fbuf[i], fbuf[i-1], fbuf[i-2], fbuf[i-3]};
      e.sel  = (i >= P * P);
      e.addr = (i < P * P) ? i / 4 : (i - P * P) / 4;
      e.cyc  = cyc;
      exp_q.push_back(e);
    end
    if (i == FRAME_BYTES - 1 && last) begin
      start_q.push_back(cyc + 1);
      hold = 1'b1;
    end
  endtask

  task automatic send_frame(input int pat, input int n, input int last_at, input bit gapped);
    for (int i = 0; i < n; i++) begin
      if (gapped && $urandom_range(0, 2) == 0) begin
        s_valid = 1'b0;
        idle($urandom_range(1, 3));
      end
      send_byte(i, bval(pat, i), i == last_at);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic wait_start();
    int s0;
    s0 = start_cnt;
    for (int k = 0; k < 20 && start_cnt == s0; k++) idle(1);
    if (start_cnt == s0) begin
      n_tests++;
      n_fail++;
      $display("FAIL start_timeout: no start seen, expected one");
    end
  endtask

  task automatic finish_mm(input int delay, output int u);
    logic r;
    idle(delay);
    mm_done = 1'b1;
    step(r);
    mm_done = 1'b0;
    hold    = 1'b0;
    u       = cyc;
    chk("ready_after_done", 64'({s_ready, busy}), 64'(2'b10));
  endtask

  initial begin
    int w0, a0, s0, u;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", 64'(outs()), 64'({1'b1, 43'd0}));
    resetn = 1'b1;
    idle(2);

    // nominal frame
    w0 = wr_cnt; a0 = wr_a_cnt; s0 = start_cnt;
    send_frame(0, FRAME_BYTES, FRAME_BYTES - 1, 1'b0);
    wait_start();
    chk("t1_writes", 64'(wr_cnt - w0), 64'(18));
    chk("t1_a_writes", 64'(wr_a_cnt - a0), 64'(16));
    chk("t1_a_word0", 64'(log_a[0]), 64'(32'h03020100));
    chk("t1_b_word1", 64'(log_b[1]), 64'(32'h47464544));
    chk("t1_pending", 64'(exp_q.size()), 64'(0));
    idle(10);
    finish_mm(0, u);
    chk("t1_starts", 64'(start_cnt - s0), 64'(1));

    // gapped input
    w0 = wr_cnt; s0 = start_cnt;
    send_frame(0, FRAME_BYTES, FRAME_BYTES - 1, 1'b1);
    wait_start();
    chk("t2_writes", 64'(wr_cnt - w0), 64'(18));
    chk("t2_pending", 64'(exp_q.size()), 64'(0));
    finish_mm(3, u);
    chk("t2_starts", 64'(start_cnt - s0), 64'(1));

    // early s_last on byte 40
    w0 = wr_cnt; a0 = wr_a_cnt; s0 = start_cnt;
    send_frame(0, 41, 40, 1'b0);
    idle(3);
    chk("t3_err_idle", 64'({err, busy, s_ready}), 64'(3'b101));
    chk("t3_a_writes", 64'(wr_a_cnt - a0), 64'(10));
    chk("t3_a_word9", 64'(log_a[9]), 64'(32'h27262524));
    chk("t3_no_start", 64'(start_cnt - s0), 64'(0));
    w0 = wr_cnt;
    send_byte(0, bval(0, 0), 1'b0);
    chk("t3_err_cleared", 64'(err), 64'(0));
    for (int i = 1; i < FRAME_BYTES; i++) send_byte(i, bval(0, i), i == FRAME_BYTES - 1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_start();
    chk("t3_good_writes", 64'(wr_cnt - w0), 64'(18));
    finish_mm(2, u);

    // missing s_last, then flush three bytes
    w0 = wr_cnt; s0 = start_cnt;
    for (int i = 0; i < FRAME_BYTES; i++) send_byte(i, bval(0, i), 1'b0);
    chk("t4_err_set", 64'({err, busy}), 64'(2'b11));
    for (int i = FRAME_BYTES; i < FRAME_BYTES + 3; i++) send_byte(i, 8'hE0, i == FRAME_BYTES + 2);
    s_valid = 1'b0; s_last = 1'b0;
    idle(3);
    chk("t4_err_idle", 64'({err, busy, s_ready}), 64'(3'b101));
    chk("t4_writes", 64'(wr_cnt - w0), 64'(18));
    chk("t4_no_start", 64'(start_cnt - s0), 64'(0));

    // reset after byte 30, then a fresh frame
    send_frame(0, 31, -1, 1'b0);
    resetn = 1'b0;
    #1;
    chk("t5_reset_outputs", 64'(outs()), 64'({1'b1, 43'd0}));
    idle(2);
    resetn = 1'b1;
    idle(1);
    chk("t5_pending", 64'(exp_q.size()), 64'(0));
    w0 = wr_cnt;
    send_frame(1, FRAME_BYTES, FRAME_BYTES - 1, 1'b0);
    wait_start();
    chk("t5_a_word0", 64'(log_a[0]), 64'(32'h83828180));
    chk("t5_writes", 64'(wr_cnt - w0), 64'(18));
    finish_mm(1, u);

    // back-to-back frames
    s0 = start_cnt;
    send_frame(0, FRAME_BYTES, FRAME_BYTES - 1, 1'b0);
    wait_start();
    finish_mm(4, u);
    send_byte(0, bval(1, 0), 1'b0);
    chk("t6_first_accept_cycle", 64'(last_acc), 64'(u + 1));
    for (int i = 1; i < FRAME_BYTES; i++) send_byte(i, bval(1, i), i == FRAME_BYTES - 1);
    s_valid = 1'b0; s_last = 1'b0;
    wait_start();
    finish_mm(5, u);
    chk("t6_starts", 64'(start_cnt - s0), 64'(2));
    chk("t6_pending", 64'(exp_q.size() + start_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
